// File: rtl/pes_fmul_pkg.sv
// Shared definitions for the pes_fmul request scheduler.
// Holds the FSM state encoding, operand/product widths, the default abort
// timeout and the operand-pair payload type handed to the datapath.
package pes_fmul_pkg;

  localparam int unsigned OP_W        = 4;
  localparam int unsigned PROD_W      = 7;
  localparam int unsigned TIMEOUT_DEF = 20;
  localparam int unsigned STATE_W     = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_LAUNCH = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT   = 2'd2;
  localparam logic [STATE_W-1:0] S_RESP   = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0] mplier;
    logic [OP_W-1:0] mcand;
  } operands_t;

endpackage

// File: rtl/pes_fmul_sched_if.sv
// Bus bundle for pes_fmul_sched: two requesters, the shared multiplier
// datapath and the result consumer.
//   slave  : the scheduler (consumes Req/operands/Product/Done/RReady)
//   master : the environment (requesters, datapath, result sink)
interface pes_fmul_sched_if;
  import pes_fmul_pkg::*;

  logic              Req0;
  logic              Req1;
  logic [OP_W-1:0]   A0;
  logic [OP_W-1:0]   B0;
  logic [OP_W-1:0]   A1;
  logic [OP_W-1:0]   B1;
  logic              Gnt0;
  logic              Gnt1;
  logic              St;
  logic [OP_W-1:0]   Mplier;
  logic [OP_W-1:0]   Mcand;
  logic [PROD_W-1:0] Product;
  logic              Done;
  logic [PROD_W-1:0] Result;
  logic              RValid;
  logic              RId;
  logic              RReady;
  logic              Busy;
  logic              Err;

  modport slave (
    input  Req0, Req1, A0, B0, A1, B1, Product, Done, RReady,
    output Gnt0, Gnt1, St, Mplier, Mcand, Result, RValid, RId, Busy, Err
  );

  modport master (
    output Req0, Req1, A0, B0, A1, B1, Product, Done, RReady,
    input  Gnt0, Gnt1, St, Mplier, Mcand, Result, RValid, RId, Busy, Err
  );

endinterface

// File: rtl/pes_rr_arb2.sv
// Two-way round-robin picker.
//   req   : request vector {req1, req0}
//   ptr   : index of the requester favoured on a tie
//   gnt_c : one-hot combinational grant (all zero when nothing requests)
module pes_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt_c
);

  // A lone request always wins; a tie goes to the favoured requester.
  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/pes_fmul_sched.sv
// Scheduler sharing one pes_fmul multiplier datapath between two requesters.
// Ports:
//   CLK : clock, rising-edge
//   Rst : asynchronous active-high reset
//   bus : pes_fmul_sched_if.slave -- requests/operands in, Gnt0/Gnt1 grant
//         pulses, St/Mplier/Mcand to the datapath, Product/Done back, and
//         Result/RValid/RId with RReady to the consumer, plus Busy and Err.
// All outputs are registered; St, Busy and RValid are decoded from the
// next state so they line up exactly with LAUNCH, non-IDLE and RESP.
module pes_fmul_sched
  import pes_fmul_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            CLK,
  input  logic            Rst,
  pes_fmul_sched_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic               ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  operands_t          ops, ops_nxt;
  logic [PROD_W-1:0]  result, result_nxt;
  logic               rid, rid_nxt;
  logic               gnt0, gnt0_nxt;
  logic               gnt1, gnt1_nxt;
  logic               err, err_nxt;
  logic               st, st_nxt;
  logic               busy, busy_nxt;
  logic               rvalid, rvalid_nxt;
  logic [1:0]         gnt_c;

  pes_rr_arb2 u_arb (
    .req   ({bus.Req1, bus.Req0}),
    .ptr   (ptr),
    .gnt_c (gnt_c)
  );

  // Next-state and next-register values.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    ops_nxt    = ops;
    result_nxt = result;
    rid_nxt    = rid;
    gnt0_nxt   = 1'b0;
    gnt1_nxt   = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (gnt_c != 2'b00) begin
          state_nxt = S_LAUNCH;
          gnt0_nxt  = gnt_c[0];
          gnt1_nxt  = gnt_c[1];
          rid_nxt   = gnt_c[1];
          // Favour the other requester next time.
          ptr_nxt   = gnt_c[0];
          if (gnt_c[1]) begin
            ops_nxt.mplier = bus.A1;
            ops_nxt.mcand  = bus.B1;
          end else begin
            ops_nxt.mplier = bus.A0;
            ops_nxt.mcand  = bus.B0;
          end
        end
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        // cnt == 0 is the first WAIT cycle, where Done may be left over
        // from the previous operation. Done beats the timeout.
        if (bus.Done && (cnt != '0)) begin
          result_nxt = bus.Product;
          state_nxt  = S_RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.RReady) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign st_nxt     = (state_nxt == S_LAUNCH);
  assign busy_nxt   = (state_nxt != S_IDLE);
  assign rvalid_nxt = (state_nxt == S_RESP);

  // State and output registers.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state  <= S_IDLE;
      ptr    <= 1'b0;
      cnt    <= '0;
      ops    <= '0;
      result <= '0;
      rid    <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      err    <= 1'b0;
      st     <= 1'b0;
      busy   <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      ops    <= ops_nxt;
      result <= result_nxt;
      rid    <= rid_nxt;
      gnt0   <= gnt0_nxt;
      gnt1   <= gnt1_nxt;
      err    <= err_nxt;
      st     <= st_nxt;
      busy   <= busy_nxt;
      rvalid <= rvalid_nxt;
    end
  end

  assign bus.Gnt0   = gnt0;
  assign bus.Gnt1   = gnt1;
  assign bus.St     = st;
  assign bus.Mplier = ops.mplier;
  assign bus.Mcand  = ops.mcand;
  assign bus.Result = result;
  assign bus.RValid = rvalid;
  assign bus.RId    = rid;
  assign bus.Busy   = busy;
  assign bus.Err    = err;

endmodule

// File: tb/tb_pes_fmul_sched.sv
// Testbench for pes_fmul_sched: directed requester stimulus, a behavioural
// multiplier datapath, and a scoreboard monitor that checks every grant and
// every accepted result against queued expectations.
module tb_pes_fmul_sched;
  import pes_fmul_pkg::*;

  logic CLK = 1'b0;
  logic Rst;

  pes_fmul_sched_if bus ();

  pes_fmul_sched #(.TIMEOUT(20)) dut (
    .CLK (CLK),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int err_cnt = 0;

  typedef struct { int idx; int a; int b; } gexp_t;
  typedef struct { int rid; int res; } rexp_t;
  gexp_t gnt_q[$];
  rexp_t res_q[$];
  gexp_t mon_ge;
  rexp_t mon_re;

  // datapath model: 0 = Done after dp_delay, 1 = stale Done held, 2 = never
  int         dp_mode   = 0;
  int         dp_delay  = 6;
  int         dp_cnt    = 0;
  bit         dp_active = 1'b0;
  logic [6:0] dp_new    = '0;
  localparam logic [6:0] STALE = 7'd99;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Datapath model, driven on the falling edge.
  always @(negedge CLK) begin
    if (Rst) begin
      dp_active   = 1'b0;
      bus.Done    = 1'b0;
      bus.Product = '0;
    end else begin
      if (bus.St) begin
        dp_active = 1'b1;
        dp_cnt    = 0;
        dp_new    = 7'(int'(bus.Mplier) * int'(bus.Mcand));
      end else if (dp_active) begin
        dp_cnt++;
      end
      case (dp_mode)
        0: begin
          if (dp_active && dp_cnt == dp_delay) begin
            bus.Done = 1'b1; bus.Product = dp_new; dp_active = 1'b0;
          end else begin
            bus.Done = 1'b0;
          end
        end
        1: begin
          if (dp_active && dp_cnt == 2) begin
            bus.Done = 1'b1; bus.Product = dp_new; dp_active = 1'b0;
          end else begin
            bus.Done = 1'b1; bus.Product = STALE;
          end
        end
        default: bus.Done = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor.
  always @(negedge CLK) begin
    if (!Rst) begin
      if (bus.Gnt0 || bus.Gnt1) begin
        if (gnt_q.size() == 0) begin
          n_total++;
          $display("FAIL gnt_unexpected: got Gnt0=%0d Gnt1=%0d, expected no grant", bus.Gnt0, bus.Gnt1);
        end else begin
          mon_ge = gnt_q.pop_front();
          check("gnt_onehot", 32'(bus.Gnt0 ^ bus.Gnt1), 32'd1);
          check("gnt_idx", 32'(bus.Gnt1), 32'(mon_ge.idx));
          check("gnt_mplier", 32'(bus.Mplier), 32'(mon_ge.a));
          check("gnt_mcand", 32'(bus.Mcand), 32'(mon_ge.b));
        end
      end
      if (bus.RValid && bus.RReady) begin
        if (res_q.size() == 0) begin
          n_total++;
          $display("FAIL resp_unexpected: got Result=%0d RId=%0d, expected no response", bus.Result, bus.RId);
        end else begin
          mon_re = res_q.pop_front();
          check("resp_rid", 32'(bus.RId), 32'(mon_re.rid));
          check("resp_result", 32'(bus.Result), 32'(mon_re.res));
        end
      end
      if (bus.Err) err_cnt++;
    end
  end

  task automatic wait_gnt(output int g);
    g = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (bus.Gnt0 || bus.Gnt1) begin
        g = bus.Gnt1 ? 1 : 0;
        return;
      end
    end
    n_total++;
    $display("FAIL gnt_timeout: got no grant in 60 cycles, expected a grant");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!bus.Busy) return;
    end
    n_total++;
    $display("FAIL idle_timeout: got Busy=1 for 100 cycles, expected 0");
  endtask

  task automatic do_op(input int idx, input int a, input int b, input int prod);
    int g;
    gnt_q.push_back('{idx, a, b});
    res_q.push_back('{idx, prod});
    @(posedge CLK); #1;
    if (idx == 0) begin
      bus.A0 = 4'(a); bus.B0 = 4'(b); bus.Req0 = 1'b1;
    end else begin
      bus.A1 = 4'(a); bus.B1 = 4'(b); bus.Req1 = 1'b1;
    end
    wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    int n;
    int rv;
    logic [10:0] exp_stall;

    Rst = 1'b1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
    bus.RReady = 1'b1;

    // Reset values
    repeat (2) @(negedge CLK);
    check("reset_ctrl", 32'({bus.Busy, bus.St, bus.RValid, bus.Err, bus.Gnt0, bus.Gnt1, bus.RId}), 32'd0);
    check("reset_data", 32'({bus.Result, bus.Mplier, bus.Mcand}), 32'd0);
    @(posedge CLK); #1;
    Rst = 1'b0;

    // Single op 5*3, Done 6 cycles after St
    dp_delay = 6;
    gnt_q.push_back('{0, 5, 3});
    res_q.push_back('{0, 15});
    bus.A0 = 4'd5; bus.B0 = 4'd3; bus.Req0 = 1'b1;
    wait_gnt(g);
    check("st_at_grant", 32'(bus.St), 32'd1);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      n++;
      if (i == 0) check("st_one_cycle", 32'(bus.St), 32'd0);
      if (bus.RValid) break;
    end
    check("rvalid_latency", 32'(n), 32'd7);
    wait_idle();

    // Lone requests win regardless of the pointer
    dp_delay = 3;
    do_op(0, 9, 9, 81);
    do_op(1, 7, 9, 63);

    // Both requests held: alternate 0,1,0,1
    gnt_q.push_back('{0, 2, 3}); res_q.push_back('{0, 6});
    gnt_q.push_back('{1, 4, 5}); res_q.push_back('{1, 20});
    gnt_q.push_back('{0, 2, 3}); res_q.push_back('{0, 6});
    gnt_q.push_back('{1, 4, 5}); res_q.push_back('{1, 20});
    @(posedge CLK); #1;
    bus.A0 = 4'd2; bus.B0 = 4'd3; bus.A1 = 4'd4; bus.B1 = 4'd5;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    for (int k = 0; k < 4; k++) wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    wait_idle();

    // Stale Done ignored on the first WAIT cycle
    dp_mode = 1;
    do_op(1, 3, 4, 12);
    dp_mode = 0;

    // Timeout abort
    dp_mode = 2;
    gnt_q.push_back('{0, 1, 1});
    @(posedge CLK); #1;
    bus.A0 = 4'd1; bus.B0 = 4'd1; bus.Req0 = 1'b1;
    wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0;
    n = 0; rv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      n++;
      if (bus.RValid) rv = 1;
      if (bus.Err) break;
    end
    check("err_latency", 32'(n), 32'd21);
    check("err_busy_low", 32'(bus.Busy), 32'd0);
    check("no_rvalid_on_timeout", 32'(rv), 32'd0);
    dp_mode = 0;
    // Pointer advanced past requester 0 despite the abort
    dp_delay = 4;
    gnt_q.push_back('{1, 6, 7}); res_q.push_back('{1, 42});
    @(posedge CLK); #1;
    bus.A0 = 4'd1; bus.B0 = 4'd1; bus.A1 = 4'd6; bus.B1 = 4'd7;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    wait_idle();

    // Back-pressure: RReady low for 10 RESP cycles
    dp_delay = 2;
    bus.RReady = 1'b0;
    gnt_q.push_back('{0, 6, 5}); res_q.push_back('{0, 30});
    @(posedge CLK); #1;
    bus.A0 = 4'd6; bus.B0 = 4'd5; bus.Req0 = 1'b1;
    wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0;
    gnt_q.push_back('{1, 7, 8}); res_q.push_back('{1, 56});
    bus.A1 = 4'd7; bus.B1 = 4'd8; bus.Req1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.RValid) break;
    end
    exp_stall = {1'b1, 1'b0, 1'b0, 1'b0, 7'd30};
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge CLK);
      check("stall_hold", 32'({bus.RValid, bus.RId, bus.Gnt0, bus.Gnt1, bus.Result}), 32'(exp_stall));
    end
    @(posedge CLK); #1;
    bus.RReady = 1'b1;
    @(posedge CLK); #1;
    check("rvalid_drop_after_accept", 32'(bus.RValid), 32'd0);
    check("no_gnt_on_accept_edge", 32'({bus.Gnt0, bus.Gnt1}), 32'd0);
    wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req1 = 1'b0;
    wait_idle();

    // Async reset during WAIT
    dp_mode = 2;
    gnt_q.push_back('{0, 3, 3});
    @(posedge CLK); #1;
    bus.A0 = 4'd3; bus.B0 = 4'd3; bus.Req0 = 1'b1;
    wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    Rst = 1'b1;
    #1;
    check("async_reset_ctrl", 32'({bus.Busy, bus.St, bus.RValid, bus.Err, bus.Gnt0, bus.Gnt1, bus.RId}), 32'd0);
    check("async_reset_data", 32'({bus.Result, bus.Mplier, bus.Mcand}), 32'd0);
    dp_mode = 0;
    repeat (2) @(posedge CLK);
    #1;
    Rst = 1'b0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      if (bus.RValid || bus.Err) n++;
    end
    check("no_resp_after_reset", 32'(n), 32'd0);
    dp_delay = 3;
    gnt_q.push_back('{0, 4, 4}); res_q.push_back('{0, 16});
    @(posedge CLK); #1;
    bus.A0 = 4'd4; bus.B0 = 4'd4; bus.A1 = 4'd9; bus.B1 = 4'd1;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    wait_gnt(g);
    @(posedge CLK); #1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    wait_idle();

    repeat (3) @(negedge CLK);
    check("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
    check("resp_queue_drained", 32'(res_q.size()), 32'd0);
    check("err_pulses", 32'(err_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
